// File: rtl/load_pkg.sv
// Shared definitions for the load alignment/extension path: opcodes, pipe states,
// XLEN legality and the lane-select/extend helper.
package load_pkg;

    localparam logic [3:0] LD_W   = 4'd0;
    localparam logic [3:0] LD_BU  = 4'd1;
    localparam logic [3:0] LD_B   = 4'd2;
    localparam logic [3:0] LD_HU  = 4'd3;
    localparam logic [3:0] LD_H   = 4'd4;
    localparam logic [3:0] LD_WU  = 4'd5;
    localparam logic [3:0] LD_D   = 4'd6;
    localparam logic [3:0] LD_LWL = 4'd7;
    localparam logic [3:0] LD_LWR = 4'd8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    function automatic bit xlen_ok(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    // Opcodes 5/6 exist only on 64-bit datapaths, LWL/LWR only on 32-bit ones.
    function automatic logic op_legal(input logic [3:0] op, input int unsigned xlen);
        case (op)
            LD_W, LD_BU, LD_B, LD_HU, LD_H: return 1'b1;
            LD_WU, LD_D:                    return 1'(xlen == 64);
            LD_LWL, LD_LWR:                 return 1'(xlen == 32);
            default:                        return 1'b0;
        endcase
    endfunction

    // Little-endian lane select plus sign/zero extension; result is 64 bits wide.
    function automatic logic [63:0] lane_ext(input logic [3:0] op, input logic [2:0] addr,
                                             input logic [63:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        logic [63:0] r;
        b = 8'(data >> {addr, 3'b000});
        h = 16'(data >> {addr[2:1], 4'b0000});
        w = 32'(data >> {addr[2], 5'b00000});
        case (op)
            LD_BU:   r = 64'(b);
            LD_B:    r = {{56{b[7]}}, b};
            LD_HU:   r = 64'(h);
            LD_H:    r = {{48{h[15]}}, h};
            LD_W:    r = {{32{w[31]}}, w};
            LD_WU:   r = 64'(w);
            LD_D:    r = data;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_ext_comb.sv
// Combinational align/extend/merge unit with address-error detection.
// Shared between the registered load pipe and the bypass path.
module load_ext_comb
    import load_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned AW  = $clog2(XLEN / 8)
) (
    input  logic [3:0]      op_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [XLEN-1:0] rt_i,
    output logic [XLEN-1:0] res_c_o,
    output logic            exc_c_o
);

    logic [2:0]  addr3;
    logic [63:0] data64;
    logic [63:0] rt64;
    logic [63:0] lwl64;
    logic [63:0] lwr64;
    logic [63:0] val64;
    logic [5:0]  sh_r;
    logic [5:0]  sh_l;
    logic        legal;
    logic        misal;

    always_comb begin
        addr3  = 3'(addr_i);
        data64 = 64'(data_i);
        rt64   = 64'(rt_i);
        sh_r   = {1'b0, addr3[1:0], 3'b000};
        sh_l   = 6'd24 - sh_r;

        // Unaligned word merges; keep only the low 32 bits of the merged word.
        lwl64 = ((data64 << sh_l) | (rt64 & (64'h0000_0000_00FF_FFFF >> sh_r)))
                & 64'h0000_0000_FFFF_FFFF;
        lwr64 = ((data64 & 64'h0000_0000_FFFF_FFFF) >> sh_r)
                | (rt64 & ~(64'h0000_0000_FFFF_FFFF >> sh_r) & 64'h0000_0000_FFFF_FFFF);

        legal = op_legal(op_i, XLEN);
        case (op_i)
            LD_HU, LD_H: misal = addr3[0];
            LD_W, LD_WU: misal = (addr3[1:0] != 2'd0);
            LD_D:        misal = (addr3 != 3'd0);
            default:     misal = 1'b0;
        endcase

        exc_c_o = !legal || misal;
        if (exc_c_o) begin
            val64 = '0;
        end else if (op_i == LD_LWL) begin
            val64 = lwl64;
        end else if (op_i == LD_LWR) begin
            val64 = lwr64;
        end else begin
            val64 = lane_ext(op_i, addr3, data64);
        end
        res_c_o = XLEN'(val64);
    end

endmodule

// File: rtl/load_ext_pipe.sv
// Load writeback stage: combinational extend unit feeding an output register
// plus one skid entry, giving a fully registered valid/ready interface.
module load_ext_pipe
    import load_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5,
    localparam int unsigned AW   = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [AW-1:0]    in_addr,
    input  logic [XLEN-1:0]  in_data,
    input  logic [XLEN-1:0]  in_rt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_exc
);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("load_ext_pipe: XLEN must be 32 or 64");
    end

    pipe_state_e      state_q, state_d;
    logic [XLEN-1:0]  o_data_q, o_data_d, s_data_q, s_data_d;
    logic [TAG_W-1:0] o_tag_q, o_tag_d, s_tag_q, s_tag_d;
    logic             o_exc_q, o_exc_d, s_exc_q, s_exc_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [XLEN-1:0]  res_c;
    logic             exc_c;
    logic             accept_c, retire_c;
    logic             o_from_in, o_from_s, s_load, clr;

    load_ext_comb #(.XLEN(XLEN)) u_ext (
        .op_i    (in_op),
        .addr_i  (in_addr),
        .data_i  (in_data),
        .rt_i    (in_rt),
        .res_c_o (res_c),
        .exc_c_o (exc_c)
    );

    assign accept_c = in_valid && in_ready_q;
    assign retire_c = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and register-load controls; flush overrides accept and retire.
    always_comb begin
        state_d   = state_q;
        o_from_in = 1'b0;
        o_from_s  = 1'b0;
        s_load    = 1'b0;
        clr       = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            clr     = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d   = ST_ONE;
                        o_from_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept_c && retire_c) begin
                        o_from_in = 1'b1;
                    end else if (accept_c) begin
                        state_d = ST_FULL;
                        s_load  = 1'b1;
                    end else if (retire_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (retire_c) begin
                        state_d  = ST_ONE;
                        o_from_s = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        o_data_d    = o_data_q;
        o_tag_d     = o_tag_q;
        o_exc_d     = o_exc_q;
        s_data_d    = s_data_q;
        s_tag_d     = s_tag_q;
        s_exc_d     = s_exc_q;
        if (clr) begin
            o_data_d = '0;
            o_tag_d  = '0;
            o_exc_d  = 1'b0;
            s_data_d = '0;
            s_tag_d  = '0;
            s_exc_d  = 1'b0;
        end else begin
            if (o_from_in) begin
                o_data_d = res_c;
                o_tag_d  = in_tag;
                o_exc_d  = exc_c;
            end else if (o_from_s) begin
                o_data_d = s_data_q;
                o_tag_d  = s_tag_q;
                o_exc_d  = s_exc_q;
            end
            if (s_load) begin
                s_data_d = res_c;
                s_tag_d  = in_tag;
                s_exc_d  = exc_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            o_data_q    <= '0;
            o_tag_q     <= '0;
            o_exc_q     <= 1'b0;
            s_data_q    <= '0;
            s_tag_q     <= '0;
            s_exc_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            o_data_q    <= o_data_d;
            o_tag_q     <= o_tag_d;
            o_exc_q     <= o_exc_d;
            s_data_q    <= s_data_d;
            s_tag_q     <= s_tag_d;
            s_exc_q     <= s_exc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = o_data_q;
    assign out_tag   = o_tag_q;
    assign out_exc   = o_exc_q;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Self-checking bench for load_ext_pipe: 32- and 64-bit instances against a
// byte-level reference model and a FIFO scoreboard.
module tb_load_ext_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b1, out_exc32;
    logic [3:0]  in_op32 = '0;
    logic [1:0]  in_addr32 = '0;
    logic [31:0] in_data32 = '0, in_rt32 = '0, out_data32;
    logic [4:0]  in_tag32 = '0, out_tag32;

    logic        in_valid64 = 1'b0, in_ready64, out_valid64, out_ready64 = 1'b1, out_exc64;
    logic [3:0]  in_op64 = '0;
    logic [2:0]  in_addr64 = '0;
    logic [63:0] in_data64 = '0, in_rt64 = '0, out_data64;
    logic [4:0]  in_tag64 = '0, out_tag64;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        exc;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  addr;
        logic [63:0] data;
        logic [63:0] rt;
        logic [63:0] exp;
        logic        exc;
    } vec_t;

    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    load_ext_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_op(in_op32),
        .in_addr(in_addr32), .in_data(in_data32), .in_rt(in_rt32), .in_tag(in_tag32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
        .out_tag(out_tag32), .out_exc(out_exc32)
    );

    load_ext_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_op(in_op64),
        .in_addr(in_addr64), .in_data(in_data64), .in_rt(in_rt64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
        .out_tag(out_tag64), .out_exc(out_exc64)
    );

    // Reference: gather bytes of the access, extend by arithmetic on the top bit.
    function automatic void model(input int xlen, input logic [3:0] op, input int addr,
                                  input logic [63:0] d, input logic [63:0] rt,
                                  output logic [63:0] res, output logic exc);
        int size;
        bit sgn;
        bit legal;
        logic [63:0] v;
        logic [31:0] w;
        int k;
        size = 0; sgn = 0; legal = 1; res = '0; exc = 1'b0;
        case (op)
            4'd0: begin size = 4; sgn = 1; end
            4'd1: begin size = 1; sgn = 0; end
            4'd2: begin size = 1; sgn = 1; end
            4'd3: begin size = 2; sgn = 0; end
            4'd4: begin size = 2; sgn = 1; end
            4'd5: begin size = 4; legal = (xlen == 64); end
            4'd6: begin size = 8; legal = (xlen == 64); end
            4'd7, 4'd8: legal = (xlen == 32);
            default: legal = 0;
        endcase
        if (!legal) begin
            exc = 1'b1;
            return;
        end
        k = addr % 4;
        if (op == 4'd7) begin
            w = (d[31:0] << (8 * (3 - k))) | (rt[31:0] & ((32'd1 << (8 * (3 - k))) - 32'd1));
            res = {32'd0, w};
            return;
        end
        if (op == 4'd8) begin
            w = (d[31:0] >> (8 * k)) | (rt[31:0] & ~(32'hFFFF_FFFF >> (8 * k)));
            res = {32'd0, w};
            return;
        end
        if ((addr % size) != 0) begin
            exc = 1'b1;
            return;
        end
        v = '0;
        for (int i = 0; i < size; i++) v = v | (64'(d[8 * (addr + i) +: 8]) << (8 * i));
        if (sgn && v[8 * size - 1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
        res = (xlen == 32) ? {32'd0, v[31:0]} : v;
    endfunction

    task automatic send32(input vec_t t, input logic [4:0] tag);
        @(negedge clk);
        in_op32 = t.op; in_addr32 = t.addr[1:0]; in_data32 = t.data[31:0];
        in_rt32 = t.rt[31:0]; in_tag32 = tag; in_valid32 = 1'b1; out_ready32 = 1'b1;
        @(posedge clk);
        #1 in_valid32 = 1'b0;
        @(negedge clk);
    endtask

    task automatic send64(input vec_t t, input logic [4:0] tag);
        @(negedge clk);
        in_op64 = t.op; in_addr64 = t.addr; in_data64 = t.data;
        in_rt64 = t.rt; in_tag64 = tag; in_valid64 = 1'b1; out_ready64 = 1'b1;
        @(posedge clk);
        #1 in_valid64 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid32, in_ready32, out_exc32, out_tag32, out_data32} !== {1'b0, 1'b1, 1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset32: v=%0b rdy=%0b exc=%0b tag=%0d data=%h want 0/1/0/0/0",
                     out_valid32, in_ready32, out_exc32, out_tag32, out_data32);
        end
        checks++;
        if ({out_valid64, in_ready64, out_exc64, out_tag64, out_data64} !== {1'b0, 1'b1, 1'b0, 5'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset64: v=%0b rdy=%0b exc=%0b tag=%0d data=%h want 0/1/0/0/0",
                     out_valid64, in_ready64, out_exc64, out_tag64, out_data64);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: v=%0b rdy=%0b want 0/1", out_valid32, in_ready32);
        end
    endtask

    task automatic test_extend32();
        vec_t tv [12];
        tv[0]  = '{4'd1, 3'd0, 64'h8899AABB, 64'd0, 64'h000000BB, 1'b0};
        tv[1]  = '{4'd1, 3'd1, 64'h8899AABB, 64'd0, 64'h000000AA, 1'b0};
        tv[2]  = '{4'd1, 3'd2, 64'h8899AABB, 64'd0, 64'h00000099, 1'b0};
        tv[3]  = '{4'd1, 3'd3, 64'h8899AABB, 64'd0, 64'h00000088, 1'b0};
        tv[4]  = '{4'd2, 3'd3, 64'h8899AABB, 64'd0, 64'hFFFFFF88, 1'b0};
        tv[5]  = '{4'd2, 3'd0, 64'h8899AA3B, 64'd0, 64'h0000003B, 1'b0};
        tv[6]  = '{4'd4, 3'd2, 64'h80017FFF, 64'd0, 64'hFFFF8001, 1'b0};
        tv[7]  = '{4'd4, 3'd1, 64'h80017FFF, 64'd0, 64'h00000000, 1'b1};
        tv[8]  = '{4'd0, 3'd2, 64'h80017FFF, 64'd0, 64'h00000000, 1'b1};
        tv[9]  = '{4'd7, 3'd1, 64'h44332211, 64'hAABBCCDD, 64'h2211CCDD, 1'b0};
        tv[10] = '{4'd8, 3'd1, 64'h44332211, 64'hAABBCCDD, 64'hAA443322, 1'b0};
        tv[11] = '{4'd6, 3'd0, 64'h44332211, 64'd0, 64'h00000000, 1'b1};
        for (int i = 0; i < 12; i++) begin
            send32(tv[i], 5'(i + 3));
            checks++;
            if ({out_valid32, out_exc32, out_tag32, out_data32} !== {1'b1, tv[i].exc, 5'(i + 3), tv[i].exp[31:0]}) begin
                errors++;
                $display("FAIL ext32[%0d]: v=%0b exc=%0b tag=%0d data=%h want 1/%0b/%0d/%h",
                         i, out_valid32, out_exc32, out_tag32, out_data32, tv[i].exc, i + 3, tv[i].exp[31:0]);
            end
        end
    endtask

    task automatic test_extend64();
        vec_t tv [9];
        tv[0] = '{4'd6, 3'd0, 64'h0123456789ABCDEF, 64'd0, 64'h0123456789ABCDEF, 1'b0};
        tv[1] = '{4'd5, 3'd4, 64'hF0000000_00000000, 64'd0, 64'h00000000F0000000, 1'b0};
        tv[2] = '{4'd0, 3'd4, 64'hF0000000_00000000, 64'd0, 64'hFFFFFFFFF0000000, 1'b0};
        tv[3] = '{4'd7, 3'd0, 64'h1111, 64'h2222, 64'd0, 1'b1};
        tv[4] = '{4'd8, 3'd0, 64'h1111, 64'h2222, 64'd0, 1'b1};
        tv[5] = '{4'd6, 3'd4, 64'h0123456789ABCDEF, 64'd0, 64'd0, 1'b1};
        tv[6] = '{4'd2, 3'd7, 64'h8899AABBCCDDEEFF, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0};
        tv[7] = '{4'd3, 3'd6, 64'h8899AABBCCDDEEFF, 64'd0, 64'h0000000000008899, 1'b0};
        tv[8] = '{4'd5, 3'd2, 64'h8899AABBCCDDEEFF, 64'd0, 64'd0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            send64(tv[i], 5'(i + 1));
            checks++;
            if ({out_valid64, out_exc64, out_tag64, out_data64} !== {1'b1, tv[i].exc, 5'(i + 1), tv[i].exp}) begin
                errors++;
                $display("FAIL ext64[%0d]: v=%0b exc=%0b tag=%0d data=%h want 1/%0b/%0d/%h",
                         i, out_valid64, out_exc64, out_tag64, out_data64, tv[i].exc, i + 1, tv[i].exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ed [4];
        logic        ee [4];
        int sent = 0, retired = 0, first_ret = -1, last_ret = -1, c = 0;
        logic [63:0] r;
        logic e;
        @(negedge clk);
        while (retired < 4 && c < 20) begin
            out_ready32 = (c >= 3);
            in_valid32  = (sent < 4);
            in_op32     = 4'd2;
            in_addr32   = 2'($urandom_range(0, 3));
            in_data32   = $urandom;
            in_rt32     = $urandom;
            in_tag32    = 5'(sent + 1);
            if (sent == 2 && retired == 0) begin
                checks++;
                if (in_ready32 !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready_drop: in_ready=%0b want 0 after 2 accepts", in_ready32);
                end
            end
            if (out_valid32 && out_ready32) begin
                checks++;
                if ({out_tag32, out_exc32, out_data32} !== {5'(retired + 1), ee[retired], ed[retired][31:0]}) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: tag=%0d exc=%0b data=%h want %0d/%0b/%h", retired,
                             out_tag32, out_exc32, out_data32, retired + 1, ee[retired], ed[retired][31:0]);
                end
                if (first_ret < 0) first_ret = c;
                last_ret = c;
                retired++;
            end
            if (in_valid32 && in_ready32) begin
                model(32, in_op32, int'(in_addr32), 64'(in_data32), 64'(in_rt32), r, e);
                ed[sent] = r;
                ee[sent] = e;
                sent++;
            end
            @(negedge clk);
            c++;
        end
        in_valid32 = 1'b0;
        out_ready32 = 1'b1;
        checks++;
        if (retired != 4 || first_ret != 3 || last_ret != 6) begin
            errors++;
            $display("FAIL bp_throughput: retired=%0d first=%0d last=%0d want 4/3/6", retired, first_ret, last_ret);
        end
    endtask

    task automatic test_random();
        localparam int N = 400;
        logic [63:0] r;
        logic e;
        int rr;
        q32.delete();
        q64.delete();
        @(negedge clk);
        for (int c = 0; c < N + 8; c++) begin
            if (c < N) begin
                flush = ($urandom_range(0, 39) == 0);
                out_ready32 = ($urandom_range(0, 3) != 0);
                out_ready64 = ($urandom_range(0, 2) != 0);
                in_valid32 = ($urandom_range(0, 3) != 0);
                in_valid64 = ($urandom_range(0, 3) != 0);
            end else begin
                flush = 1'b0;
                out_ready32 = 1'b1; out_ready64 = 1'b1;
                in_valid32 = 1'b0;  in_valid64 = 1'b0;
            end
            rr = int'($urandom_range(0, 11));
            in_op32 = (rr <= 8) ? 4'(rr) : (rr == 9 ? 4'd9 : (rr == 10 ? 4'd12 : 4'd15));
            in_addr32 = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'($urandom_range(0, 3));
            in_data32 = $urandom; in_rt32 = $urandom; in_tag32 = 5'($urandom_range(0, 31));
            rr = int'($urandom_range(0, 11));
            in_op64 = (rr <= 8) ? 4'(rr) : (rr == 9 ? 4'd9 : (rr == 10 ? 4'd12 : 4'd15));
            in_addr64 = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(0, 7));
            in_data64 = {$urandom, $urandom}; in_rt64 = {$urandom, $urandom};
            in_tag64 = 5'($urandom_range(0, 31));

            checks++;
            if (in_ready32 !== (q32.size() < 2) || out_valid32 !== (q32.size() != 0)) begin
                errors++;
                $display("FAIL rnd32_hs c=%0d: rdy=%0b v=%0b want %0b/%0b", c, in_ready32, out_valid32,
                         q32.size() < 2, q32.size() != 0);
            end
            checks++;
            if (in_ready64 !== (q64.size() < 2) || out_valid64 !== (q64.size() != 0)) begin
                errors++;
                $display("FAIL rnd64_hs c=%0d: rdy=%0b v=%0b want %0b/%0b", c, in_ready64, out_valid64,
                         q64.size() < 2, q64.size() != 0);
            end

            if (flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (out_valid32 && out_ready32 && q32.size() != 0) begin
                    checks++;
                    if ({out_tag32, out_exc32, out_data32} !== {q32[0].tag, q32[0].exc, q32[0].data[31:0]}) begin
                        errors++;
                        $display("FAIL rnd32_data c=%0d: tag=%0d exc=%0b data=%h want %0d/%0b/%h", c,
                                 out_tag32, out_exc32, out_data32, q32[0].tag, q32[0].exc, q32[0].data[31:0]);
                    end
                    void'(q32.pop_front());
                end
                if (out_valid64 && out_ready64 && q64.size() != 0) begin
                    checks++;
                    if ({out_tag64, out_exc64, out_data64} !== {q64[0].tag, q64[0].exc, q64[0].data}) begin
                        errors++;
                        $display("FAIL rnd64_data c=%0d: tag=%0d exc=%0b data=%h want %0d/%0b/%h", c,
                                 out_tag64, out_exc64, out_data64, q64[0].tag, q64[0].exc, q64[0].data);
                    end
                    void'(q64.pop_front());
                end
                if (in_valid32 && in_ready32) begin
                    model(32, in_op32, int'(in_addr32), 64'(in_data32), 64'(in_rt32), r, e);
                    q32.push_back('{r, in_tag32, e});
                end
                if (in_valid64 && in_ready64) begin
                    model(64, in_op64, int'(in_addr64), in_data64, in_rt64, r, e);
                    q64.push_back('{r, in_tag64, e});
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q32.size() != 0 || q64.size() != 0 || out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL rnd_drain: left32=%0d left64=%0d v32=%0b v64=%0b want all empty",
                     q32.size(), q64.size(), out_valid32, out_valid64);
        end
    endtask

    task automatic test_flush_reset();
        vec_t t;
        @(negedge clk);
        out_ready32 = 1'b0;
        in_valid32 = 1'b1; in_op32 = 4'd1; in_addr32 = 2'd0; in_data32 = 32'h11; in_tag32 = 5'd1;
        @(negedge clk);
        in_data32 = 32'h22; in_tag32 = 5'd2;
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1) begin
            errors++;
            $display("FAIL flush_fill: rdy=%0b v=%0b want 0/1", in_ready32, out_valid32);
        end
        flush = 1'b1; in_data32 = 32'h33; in_tag32 = 5'd3; out_ready32 = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid32 = 1'b0;
        checks++;
        if ({out_valid32, in_ready32, out_exc32, out_tag32, out_data32} !== {1'b0, 1'b1, 1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL flush_clear: v=%0b rdy=%0b exc=%0b tag=%0d data=%h want 0/1/0/0/0",
                     out_valid32, in_ready32, out_exc32, out_tag32, out_data32);
        end
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: v=%0b want 0 (beat offered with flush must vanish)", out_valid32);
        end

        in_valid32 = 1'b1; in_op32 = 4'd2; in_data32 = 32'h80; in_tag32 = 5'd9;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid32, in_ready32, out_exc32, out_tag32, out_data32} !== {1'b0, 1'b1, 1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL async_reset: v=%0b rdy=%0b exc=%0b tag=%0d data=%h want 0/1/0/0/0",
                     out_valid32, in_ready32, out_exc32, out_tag32, out_data32);
        end
        in_valid32 = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: v=%0b rdy=%0b want 0/1", out_valid32, in_ready32);
        end
        t = '{4'd3, 3'd2, 64'hBEEF_1234, 64'd0, 64'h0000BEEF, 1'b0};
        send32(t, 5'd17);
        checks++;
        if ({out_valid32, out_exc32, out_tag32, out_data32} !== {1'b1, 1'b0, 5'd17, 32'h0000BEEF}) begin
            errors++;
            $display("FAIL post_reset_beat: v=%0b exc=%0b tag=%0d data=%h want 1/0/17/0000beef",
                     out_valid32, out_exc32, out_tag32, out_data32);
        end
    endtask

    initial begin
        test_reset();
        test_extend32();
        test_extend64();
        test_backpressure();
        test_random();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_ext_pipe.md
# load_ext_pipe

Pipelined load-data alignment and extension stage for the CPU memory-writeback path. Takes the raw bus word returned for a load, the low address bits and the load opcode, and produces the register write value: byte, halfword, word and (XLEN=64) doubleword loads, signed or unsigned, plus LWL/LWR merging. It also flags misaligned accesses for the exception unit. One registered output stage and a skid entry give a valid/ready interface that tolerates writeback stalls at full throughput.

## Interface
- XLEN, 32: datapath width; 32 or 64 only.
- TAG_W, 5: width of the sideband tag (destination register index).
- AW, log2(XLEN/8): derived; width of in_addr. Not overridable.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_op  in  4  load opcode (encoding below).
- in_addr  in  AW  low byte-address bits of the load.
- in_data  in  XLEN  raw aligned bus word.
- in_rt  in  XLEN  current rt value (LWL/LWR merge source).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  XLEN  extended/merged load value.
- out_tag  out  TAG_W  tag of the result beat.
- out_exc  out  1  address-error (AdEL) for this beat.

## Operation
- Opcodes 0–4 keep the existing load-extension encoding: 0 LW (32-bit, sign-extended to XLEN), 1 LBU, 2 LB, 3 LHU, 4 LH. New: 5 LWU (zero-extend 32-bit; XLEN=64 only), 6 LD (XLEN=64 only), 7 LWL, 8 LWR (XLEN=32 only). Any other code, or a width-restricted code in the wrong XLEN, is reserved.
- Lane select is little-endian: byte = in_data[8*addr +: 8]; half = in_data[16*addr[AW-1:1] +: 16]; word = in_data[32*addr[AW-1:2] +: 32].
- Alignment is enforced: half with addr[0]=1, word/LWU with addr[1:0]≠0, LD with addr≠0 → out_exc=1, out_data=0. Byte loads, LWL and LWR never fault.
- LWL, offset k=addr[1:0]: out = (in_data << 8*(3−k)) | (in_rt & ((1<<8*(3−k))−1)).
- LWR, offset k: out = (in_data >> 8k) | (in_rt & ~(32'hFFFFFFFF >> 8k)).
- Reserved opcode → out_exc=1, out_data=0.
- The datapath is purely combinational up to the output register. All state is the output register (O) and one skid register (S), each holding {data, tag, exc, valid}.

## Timing
- Reset: out_valid=0, out_data=0, out_tag=0, out_exc=0, in_ready=1, S empty.
- Latency is 1 cycle: a beat accepted at edge N appears on the out_* ports after edge N.
- Accept on in_valid&&in_ready; retire on out_valid&&out_ready.
- in_ready is registered and equals "S empty". It never depends combinationally on out_ready.
- States are EMPTY (O,S invalid), ONE (O valid), FULL (O,S valid).
  - EMPTY: accept → ONE.
  - ONE: accept with retire → ONE (O reloaded); accept without retire → FULL (beat into S); retire only → EMPTY.
  - FULL: in_ready=0; retire → ONE (S moves to O).
- Ordering is strict FIFO. S always drains into O before any newer beat.
- O holds stable while out_valid&&!out_ready.
- flush: next cycle O and S are invalid and in_ready=1. An input offered in the flush cycle is dropped. flush takes priority over accept and retire.
- Async reset mid-beat discards everything; no partial output.
- Sustained throughput is 1 beat/cycle while out_ready=1.

## Structure
- Shared package load_pkg holds the opcode localparams (LD_W … LD_LWR), the XLEN legality check, and the lane-select/extend function.
- Sub-module: load_ext_comb, the combinational align/extend/merge/exception unit, instantiated once ahead of the O/S registers. It is also reusable by the bypass path.
- Elaboration error if XLEN ∉ {32,64}.

## Test plan
- XLEN=32, in_data=0x8899AABB, sweep op 1/2 over addr 0–3 → LBU 0x000000BB/AA/99/88; LB addr 3 → 0xFFFFFF88.
- LH addr 2 on 0x8001_7FFF → 0xFFFF8001. LH addr 1 → out_exc=1, out_data=0. LW addr 2 → out_exc=1.
- LWL addr 1, in_data=0x44332211, in_rt=0xAABBCCDD → 0x2211CCDD. LWR addr 1, same inputs → 0xAA443322.
- XLEN=64: LD addr 0 returns in_data. LWU addr 4 on 0xF0000000_00000000 → 0x00000000F0000000. LW same → 0xFFFFFFFFF0000000. Op 7 → out_exc=1.
- Backpressure: stream 4 beats with out_ready low for 3 cycles. Checks: in_ready drops after 2 accepts; order and tags are preserved; no beat is lost or duplicated; once out_ready is high, 1 beat/cycle.
- Run flush while FULL, then an async reset asserted mid-stream. Checks: next cycle out_valid=0, in_ready=1, and all outputs at reset values.
